// File: rtl/rv_pkg.sv
// rv_pkg: shared RISC-V core widths, reset vector and address type
package rv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;
    typedef logic [XLEN-1:0] addr_t;
endpackage

// File: rtl/program_counter_pc_next_mux.sv
// pc_next_mux: next-PC select with priority reset > load > sequential
module pc_next_mux import rv_pkg::*; #(
    parameter int WIDTH_P = XLEN,
    parameter logic [WIDTH_P-1:0] RESET_PC_ADDR = RESET_PC_DEFAULT[WIDTH_P-1:0]
) (
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH_P-1:0] load_val,
    input  logic [WIDTH_P-1:0] pc_plus4,
    output logic [WIDTH_P-1:0] next_pc
);
    // reset wins over a simultaneous load, load wins over fall-through
    always_comb begin
        next_pc = rst ? RESET_PC_ADDR : load ? load_val : pc_plus4;
    end
endmodule

// File: rtl/program_counter.sv
// program_counter: fetch-stage PC register with +4 fall-through adder
module program_counter import rv_pkg::*; #(
    parameter int WIDTH_P = XLEN,
    parameter logic [WIDTH_P-1:0] RESET_PC_ADDR = RESET_PC_DEFAULT[WIDTH_P-1:0]
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pc_load_i,
    input  logic [WIDTH_P-1:0] pc_load_val_i,
    output logic [WIDTH_P-1:0] pc_q_o,
    output logic [WIDTH_P-1:0] pc_plus4_o
);
    logic [WIDTH_P-1:0] r_pc;
    logic [WIDTH_P-1:0] w_next_pc;
    logic [WIDTH_P-1:0] w_pc_plus4;

    assign w_pc_plus4 = r_pc + WIDTH_P'(4);
    assign pc_q_o     = r_pc;
    assign pc_plus4_o = w_pc_plus4;

    pc_next_mux #(
        .WIDTH_P       (WIDTH_P),
        .RESET_PC_ADDR (RESET_PC_ADDR)
    ) u_next_mux (
        .rst      (rst_i),
        .load     (pc_load_i),
        .load_val (pc_load_val_i),
        .pc_plus4 (w_pc_plus4),
        .next_pc  (w_next_pc)
    );

    // PC changes on every edge; no enable
    always_ff @(posedge clk_i) begin
        r_pc <= w_next_pc;
    end

`ifndef SYNTHESIS
    logic r_rst_d;

    // remember that the previous edge was a reset edge
    always_ff @(posedge clk_i) begin
        r_rst_d <= rst_i;
    end

    // fall-through output must always track the register
    always_comb begin
        assert (pc_plus4_o == pc_q_o + WIDTH_P'(4));
    end

    // a reset edge must leave the reset vector in the register
    always_ff @(posedge clk_i) begin
        if (r_rst_d) assert (pc_q_o == RESET_PC_ADDR);
    end
`endif
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: directed self-checking bench for program_counter
module tb_program_counter;
    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] load_val;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    int          checks = 0;
    int          failures = 0;

    program_counter #(
        .WIDTH_P       (32),
        .RESET_PC_ADDR (32'h0)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pc_load_i     (load),
        .pc_load_val_i (load_val),
        .pc_q_o        (pc_q),
        .pc_plus4_o    (pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pc(input string tag, input logic [31:0] exp);
        check({tag, "_q"}, pc_q, exp);
        check({tag, "_plus4"}, pc_plus4, exp + 32'd4);
    endtask

    initial begin
        rst = 1'b1;
        load = 1'b0;
        load_val = 32'h0;
        tick();
        check_pc("reset_edge1", 32'h0);
        tick();
        check_pc("reset_edge2", 32'h0);
        rst = 1'b0;
        tick();
        check_pc("inc1", 32'h4);
        tick();
        check_pc("inc2", 32'h8);
        load = 1'b1;
        load_val = 32'h100;
        tick();
        check_pc("load_100", 32'h100);
        load = 1'b0;
        tick();
        check_pc("after_load", 32'h104);
        rst = 1'b1;
        #2;
        check("sync_reset_hold", pc_q, 32'h104);
        tick();
        check_pc("midrun_reset", 32'h0);
        rst = 1'b0;
        tick();
        check_pc("restart", 32'h4);
        rst = 1'b1;
        load = 1'b1;
        load_val = 32'h200;
        tick();
        check_pc("reset_over_load", 32'h0);
        rst = 1'b0;
        tick();
        check_pc("load_200", 32'h200);
        load_val = 32'h13;
        tick();
        check_pc("load_unaligned", 32'h13);
        load_val = 32'hFFFF_FFFC;
        tick();
        check_pc("load_top", 32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4, 32'h0);
        load = 1'b0;
        tick();
        check_pc("wrap_inc", 32'h0);
        tick();
        check_pc("post_wrap", 32'h4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
